// File: rtl/mem_port_arbiter.sv
// Arbitrates the single MMU memory port between instruction fetch and the data stage.
// One access at a time: grant, hold strobes WAIT_CYCLES cycles, ack, one turnaround cycle.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_byte,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_if,
  output logic        stall_d,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_byte,
  input  logic [31:0] mmu_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_d_q, last_d_d;
  logic             gnt_d_q, gnt_d_d;
  logic             grant_data;
  logic             mmu_read_q, mmu_read_d;
  logic             mmu_write_q, mmu_write_d;
  logic [31:0]      mmu_addr_q, mmu_addr_d;
  logic [31:0]      mmu_wdata_q, mmu_wdata_d;
  logic             mmu_byte_q, mmu_byte_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    gnt_d_d     = gnt_d_q;
    grant_data  = 1'b0;
    mmu_read_d  = mmu_read_q;
    mmu_write_d = mmu_write_q;
    mmu_addr_d  = mmu_addr_q;
    mmu_wdata_d = mmu_wdata_q;
    mmu_byte_d  = mmu_byte_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          // Data wins a tie unless it also took the previous grant.
          grant_data = d_req && !(if_req && last_d_q);
          if (grant_data) begin
            mmu_addr_d  = d_addr;
            mmu_wdata_d = d_wdata;
            mmu_byte_d  = d_byte;
            mmu_read_d  = ~d_we;
            mmu_write_d = d_we;
          end else begin
            mmu_addr_d  = if_addr;
            mmu_wdata_d = '0;
            mmu_byte_d  = 1'b0;
            mmu_read_d  = 1'b1;
            mmu_write_d = 1'b0;
          end
          gnt_d_d  = grant_data;
          last_d_d = grant_data;
          cnt_d    = CNT_W'(WAIT_CYCLES - 1);
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mmu_read_d  = 1'b0;
          mmu_write_d = 1'b0;
          if (mmu_read_q) begin
            if (gnt_d_q) d_rdata_d  = mmu_rdata;
            else         if_rdata_d = mmu_rdata;
          end
          if (gnt_d_q) d_ack_d  = 1'b1;
          else         if_ack_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      gnt_d_q     <= 1'b0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      mmu_addr_q  <= '0;
      mmu_wdata_q <= '0;
      mmu_byte_q  <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      gnt_d_q     <= gnt_d_d;
      mmu_read_q  <= mmu_read_d;
      mmu_write_q <= mmu_write_d;
      mmu_addr_q  <= mmu_addr_d;
      mmu_wdata_q <= mmu_wdata_d;
      mmu_byte_q  <= mmu_byte_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mmu_read  = mmu_read_q;
  assign mmu_write = mmu_write_q;
  assign mmu_addr  = mmu_addr_q;
  assign mmu_wdata = mmu_wdata_q;
  assign mmu_byte  = mmu_byte_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_d   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single accesses, arbitration, reset abort,
// and a WAIT_CYCLES=1 instance for the minimum-latency cadence.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, d_byte;
  logic [31:0] if_addr, d_addr, d_wdata, mmu_rdata;
  logic [31:0] if_rdata, d_rdata, mmu_addr, mmu_wdata;
  logic        if_ack, d_ack, stall_if, stall_d, mmu_read, mmu_write, mmu_byte;

  logic        rst1, if_req1, if_ack1, mmu_read1, mmu_write1, mmu_byte1;
  logic        d_ack1, stall_if1, stall_d1;
  logic [31:0] if_addr1, mmu_rdata1, if_rdata1, d_rdata1, mmu_addr1, mmu_wdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte(d_byte),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_if(stall_if), .stall_d(stall_d),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_byte(mmu_byte), .mmu_rdata(mmu_rdata)
  );

  mem_port_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_byte(1'b0),
    .d_rdata(d_rdata1), .d_ack(d_ack1), .stall_if(stall_if1), .stall_d(stall_d1),
    .mmu_read(mmu_read1), .mmu_write(mmu_write1), .mmu_addr(mmu_addr1),
    .mmu_wdata(mmu_wdata1), .mmu_byte(mmu_byte1), .mmu_rdata(mmu_rdata1)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    bit          byte_m;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] exp_rdata;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic sb_push(input bit is_d, input logic [31:0] addr, input logic [31:0] exp_rdata);
    sb_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.exp_rdata = exp_rdata;
    sb_q.push_back(e);
  endtask

  // Scoreboard: strobed address must match the oldest pending request; ack pops it.
  always @(negedge clk) begin : mon
    sb_t e;
    if (if_ack || d_ack) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ack_owner", {30'd0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
        chk("sb_rdata", e.is_d ? d_rdata : if_rdata, e.exp_rdata);
      end
    end else if ((mmu_read || mmu_write) && sb_q.size() != 0) begin
      chk("sb_mmu_addr", mmu_addr, sb_q[0].addr);
    end
  end

  // Entered just after a posedge in an IDLE cycle; leaves the same way.
  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_byte = v.byte_m;
      if_req = 1'b0;
    end else begin
      if_req = 1'b1; if_addr = v.addr; d_req = 1'b0;
    end
    mmu_rdata = v.rdata;
    sb_push(v.is_d, v.addr, v.is_d ? v.exp_d : v.exp_if);
    @(negedge clk);
    chk("c0_stall", {30'd0, stall_if, stall_d}, v.is_d ? 32'd1 : 32'd2);
    chk("c0_strobe", {30'd0, mmu_read, mmu_write}, 32'd0);
    for (int c = 1; c <= W; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (v.is_d) begin
          d_addr = v.addr + 32'd4; d_wdata = ~v.wdata; d_byte = ~v.byte_m; d_we = ~v.we;
          if (v.drop) d_req = 1'b0;
        end else begin
          if_addr = v.addr + 32'd4;
          if (v.drop) if_req = 1'b0;
        end
      end
      @(negedge clk);
      chk("acc_strobe", {30'd0, mmu_read, mmu_write},
          v.is_d ? (v.we ? 32'd1 : 32'd2) : 32'd2);
      chk("acc_addr", mmu_addr, v.addr);
      chk("acc_wdata", mmu_wdata, v.is_d ? v.wdata : 32'd0);
      chk("acc_byte", {31'd0, mmu_byte}, {31'd0, v.is_d & v.byte_m});
      chk("acc_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
      chk("acc_stall", {30'd0, stall_if, stall_d},
          v.drop ? 32'd0 : (v.is_d ? 32'd1 : 32'd2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_which", {30'd0, if_ack, d_ack}, v.is_d ? 32'd1 : 32'd2);
    chk("ack_strobe", {30'd0, mmu_read, mmu_write}, 32'd0);
    chk("ack_stall", {30'd0, stall_if, stall_d}, 32'd0);
    chk("ack_if_rdata", if_rdata, v.exp_if);
    chk("ack_d_rdata", d_rdata, v.exp_d);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("post_ack_clear", {30'd0, if_ack, d_ack}, 32'd0);
    chk("post_strobe", {30'd0, mmu_read, mmu_write}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mmu_rdata = '0;
    rst1 = 1'b1; if_req1 = 1'b0; if_addr1 = '0; mmu_rdata1 = '0;

    //            is_d we byte drop addr          wdata         rdata         exp_if        exp_d
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80000010, 32'h00000000, 32'h3C011234, 32'h3C011234, 32'h00000000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80400003, 32'h000000A5, 32'h11111111, 32'h3C011234, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h00000000, 32'hCAFEF00D, 32'h3C011234, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h80000014, 32'h00000000, 32'h24020005, 32'h24020005, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h80000100, 32'h12345678, 32'h99999999, 32'h24020005, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1F000001, 32'h00000000, 32'h00000041, 32'h24020005, 32'h00000041};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80000018, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000041};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h80000200, 32'h00000000, 32'h0BADF00D, 32'hFFFFFFFF, 32'h0BADF00D};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", {30'd0, mmu_read, mmu_write}, 32'd0);
    chk("rst_addr", mmu_addr, 32'd0);
    chk("rst_wdata", mmu_wdata, 32'd0);
    chk("rst_byte", {31'd0, mmu_byte}, 32'd0);
    chk("rst_ack", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall", {30'd0, stall_if, stall_d}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters held from reset: D, I, D, I with acks in cycles 3, 7, 11, 15
    rst = 1'b1;
    if_addr = 32'h80001000; d_addr = 32'h80002000; d_we = 1'b0; d_byte = 1'b0; d_wdata = '0;
    mmu_rdata = 32'h5A5A0001;
    if_req = 1'b1; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_push(1'b1, 32'h80002000, 32'h5A5A0001);
    sb_push(1'b0, 32'h80001000, 32'h5A5A0001);
    sb_push(1'b1, 32'h80002000, 32'h5A5A0001);
    sb_push(1'b0, 32'h80001000, 32'h5A5A0001);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("arb_d_ack", {31'd0, d_ack}, (c == 3 || c == 11) ? 32'd1 : 32'd0);
      chk("arb_if_ack", {31'd0, if_ack}, (c == 7 || c == 15) ? 32'd1 : 32'd0);
      chk("arb_read", {31'd0, mmu_read}, (c % 4 == 1 || c % 4 == 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Reset during cycle 1 of a data read aborts it without ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80000040; mmu_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("abort_c1_read", {31'd0, mmu_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_c2_read", {31'd0, mmu_read}, 32'd0);
    chk("abort_c2_addr", mmu_addr, 32'd0);
    chk("abort_c2_d_rdata", d_rdata, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_no_ack", {31'd0, d_ack}, 32'd0);
    end
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80000040, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
    run_vec(v);

    chk("sb_drained", sb_q.size(), 32'd0);

    // WAIT_CYCLES=1: continuous fetch gives one ack every 3 cycles
    if_addr1 = 32'h80000400; mmu_rdata1 = 32'h01234567; if_req1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("w1_ack", {31'd0, if_ack1}, (c % 3 == 2) ? 32'd1 : 32'd0);
      chk("w1_read", {31'd0, mmu_read1}, (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c % 3 == 1) chk("w1_addr", mmu_addr1, 32'h80000400);
      if (c % 3 == 2) chk("w1_rdata", if_rdata1, 32'h01234567);
      @(posedge clk); #1;
    end
    if_req1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single MMU memory port (SRAM banks plus UART window) between the instruction-fetch stage and the data (MEM) stage.
- Latches one request at a time and drives the MMU strobes, address, write data and byte mode for a fixed number of cycles.
- Captures read data, then returns a one-cycle ack to the granted requester.
- Generates per-stage stall signals for the pipeline controller. Sits between the CPU pipeline and MMU.

Parameters:
WAIT_CYCLES, 2, cycles the MMU strobe is held per access (legal range 1..15; 0 illegal)
CNT_W, 4, width of the wait counter (must hold WAIT_CYCLES-1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request (word read); held until if_ack
if_addr  in  32  fetch address
if_rdata  out  32  fetched word, valid in the if_ack cycle and held until the next fetch capture
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data address
d_wdata  in  32  write data
d_byte  in  1  byte-mode access
d_rdata  out  32  read data, valid in the d_ack cycle and held until the next data read capture
d_ack  out  1  one-cycle completion pulse for data
stall_if  out  1  if_req & ~if_ack (combinational)
stall_d  out  1  d_req & ~d_ack (combinational)
mmu_read  out  1  MMU if_read strobe
mmu_write  out  1  MMU if_write strobe
mmu_addr  out  32  MMU address
mmu_wdata  out  32  MMU input_data
mmu_byte  out  1  MMU bytemode
mmu_rdata  in  32  MMU output_data

Behaviour:
- All outputs except stall_if/stall_d are registered.
- Reset values: mmu_read=0, mmu_write=0, mmu_addr=0, mmu_wdata=0, mmu_byte=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, state=IDLE, cnt=0, last_d=0.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - With no request, the strobes stay low.
  - d_req only: grant data.
  - if_req only: grant fetch.
  - Both: grant fetch if last_d=1, else grant data. Data wins ties unless it won the previous grant.
  - On grant: latch addr, wdata, byte and we into mmu_*. A fetch drives mmu_byte=0, mmu_wdata=0, mmu_read=1. A data grant drives mmu_read=~d_we and mmu_write=d_we. Then set cnt=WAIT_CYCLES-1, update last_d (1 = data), and go to ACCESS.
- ACCESS:
  - Strobes and address are held constant.
  - If cnt!=0, decrement.
  - If cnt==0: drop both strobes. For a read, capture mmu_rdata into if_rdata or d_rdata (per grant). Assert the matching ack, go to DONE.
- DONE:
  - Ack is high for exactly this cycle; strobes stay low. This is the bus-turnaround gap before the next access.
  - Requests are ignored. Clear ack, go to IDLE.
- Timing (request seen in IDLE at cycle 0):
  - Strobe high in cycles 1..WAIT_CYCLES.
  - Ack in cycle WAIT_CYCLES+1.
  - Earliest next grant decision in cycle WAIT_CYCLES+2.
  - Throughput: one access per WAIT_CYCLES+2 cycles.
- A request still high in the IDLE cycle after its ack is a new request.
- Writes never modify d_rdata. A fetch never modifies d_rdata, and a data access never modifies if_rdata.
- A requester dropping req mid-access does not abort it: the access completes and the ack is still issued.
- Input address/data changes during ACCESS are ignored (latched values are used).
- A single requester issuing back-to-back requests is never starved. With both requesters continuously requesting, grants alternate D, I, D, I.
- Reset asserted in any state:
  - Next cycle is IDLE with all reset values.
  - The in-flight access is dropped with no ack, and strobes go low immediately on that edge.
  - The requester re-issues.

Test Plan:
- Fetch read, WAIT_CYCLES=2, if_addr=0x80000010, mmu_rdata=0x3C011234:
  - mmu_read=1 in cycles 1-2; if_ack=1 only in cycle 3; if_rdata=0x3C011234; stall_if high in cycles 0-2.
- Data byte write, d_addr=0x80400003, d_wdata=0x000000A5, d_byte=1:
  - mmu_write=1, mmu_byte=1, mmu_addr=0x80400003 for 2 cycles; d_ack in cycle 3; d_rdata unchanged.
- Simultaneous if_req and d_req held high from reset:
  - Grant order D, I, D, I; acks in cycles 3, 7, 11, 15.
  - Each mmu_addr matches its requester's address.
- d_addr changed from 0x80000000 to 0x80000004 in cycle 1 of ACCESS:
  - mmu_addr stays 0x80000000 until the strobe drops; d_ack still issued.
- rst pulsed in cycle 1 of a data read:
  - Cycle 2: mmu_read=0, d_ack never asserts, state IDLE.
  - Re-raised d_req completes normally with mmu_rdata=0xDEADBEEF captured.
- WAIT_CYCLES=1, continuous if_req:
  - if_ack pulses every 3 cycles; mmu_read is never high in a DONE cycle.
